// File: rtl/funnel_pkg.sv
// Shared constants, FSM state type and mode-validity helper for the funnel arbiter.
package funnel_pkg;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned MODE_W   = 8;
  localparam int unsigned REDUCT_W = 3;

  typedef enum logic [1:0] {StIdle, StCfg, StXfer} state_e;

  // A mode is usable only when its low bits select exactly one funnel path.
  function automatic logic mode_valid(input logic [REDUCT_W-1:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

endpackage

// File: rtl/funnel_if.sv
// Upstream requester and funnel-side handshake bundle for funnel_arb.
interface funnel_if #(
  parameter int unsigned N_REQ   = funnel_pkg::N_REQ,
  parameter int unsigned MODE_W  = funnel_pkg::MODE_W,
  parameter int unsigned GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]        s_req;
  logic [N_REQ-1:0]        s_ack;
  logic [N_REQ-1:0]        s_err;
  logic [N_REQ*MODE_W-1:0] s_mode;
  logic                    f_req;
  logic                    f_ack;
  logic                    f_cfg_req;
  logic                    f_cfg_ack;
  logic [MODE_W-1:0]       f_mode;
  logic [GRANT_W-1:0]      grant;
  logic                    busy;

  // Arbiter side.
  modport slave (
    input  s_req, s_mode, f_ack, f_cfg_ack,
    output s_ack, s_err, f_req, f_cfg_req, f_mode, grant, busy
  );

  // Environment side: requesters plus funnel controller.
  modport master (
    output s_req, s_mode, f_ack, f_cfg_ack,
    input  s_ack, s_err, f_req, f_cfg_req, f_mode, grant, busy
  );
endinterface

// File: rtl/funnel_rr_pick.sv
// Combinational round-robin search: first requester strictly after i_last, with wrap.
module funnel_rr_pick #(
  parameter int unsigned N_REQ = funnel_pkg::N_REQ,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  int w_cand;

  // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_cand = 0;
    for (int off = int'(N_REQ); off >= 1; off--) begin
      w_cand = (int'(i_last) + off) % int'(N_REQ);
      if (i_req[w_cand]) begin
        o_hit = 1'b1;
        o_idx = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/funnel_arb.sv
// Round-robin arbiter funnelling N requesters onto one funnel port, reconfiguring on mode change.
module funnel_arb #(
  parameter int unsigned N_REQ  = funnel_pkg::N_REQ,
  parameter int unsigned MODE_W = funnel_pkg::MODE_W
) (
  input  logic     clk,
  input  logic     reset,
  funnel_if.slave  bus
);
  import funnel_pkg::*;

  localparam int unsigned GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             r_state;
  logic [GRANT_W-1:0] r_grant;
  logic [GRANT_W-1:0] r_last;
  logic [MODE_W-1:0]  r_mode;
  logic               r_cfg_valid;
  logic               r_cfg_req;
  logic               r_rej;

  logic               w_hit;
  logic [GRANT_W-1:0] w_idx;
  logic [MODE_W-1:0]  w_mode;
  logic               w_valid;
  logic               w_cur_req;
  logic               w_fire;

  funnel_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (GRANT_W)
  ) u_pick (
    .i_req  (bus.s_req),
    .i_last (r_last),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_mode    = bus.s_mode[int'(w_idx) * MODE_W +: MODE_W];
  assign w_valid   = mode_valid(w_mode[REDUCT_W-1:0]);
  assign w_cur_req = bus.s_req[r_grant];
  assign w_fire    = (r_state == StXfer) && w_cur_req && bus.f_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_last      <= GRANT_W'(N_REQ - 1);
      r_mode      <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_req   <= 1'b0;
      r_rej       <= 1'b0;
    end else begin
      r_rej <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // The reject-pulse cycle doubles as a bubble so the rejected request is not re-picked.
          if (w_hit && !r_rej) begin
            r_grant <= w_idx;
            if (!w_valid) begin
              r_rej  <= 1'b1;
              r_last <= w_idx;
            end else if (r_cfg_valid && (w_mode == r_mode)) begin
              r_state <= StXfer;
            end else begin
              r_state     <= StCfg;
              r_mode      <= w_mode;
              r_cfg_valid <= 1'b0;
              r_cfg_req   <= 1'b1;
            end
          end
        end
        StCfg: begin
          if (bus.f_cfg_ack) begin
            r_cfg_req   <= 1'b0;
            r_cfg_valid <= 1'b1;
            r_state     <= StXfer;
          end
        end
        StXfer: begin
          if (w_fire) begin
            r_last  <= r_grant;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Frame request and completion track the owner combinationally so a dropped request pauses it.
  always_comb begin
    bus.s_ack = '0;
    bus.s_err = '0;
    bus.f_req = 1'b0;
    if (r_state == StXfer) begin
      bus.f_req          = w_cur_req;
      bus.s_ack[r_grant] = w_fire;
    end
    if (r_rej) begin
      bus.s_ack[r_grant] = 1'b1;
      bus.s_err[r_grant] = 1'b1;
    end
  end

  assign bus.f_cfg_req = r_cfg_req;
  assign bus.f_mode    = r_mode;
  assign bus.grant     = r_grant;
  assign bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_funnel_arb.sv
// Self-checking bench for funnel_arb: directed scenarios plus randomized traffic vs a frame-level model.
module tb_funnel_arb;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Frame-level reference state.
  int         m_last;
  logic [7:0] m_mode;
  bit         m_cfg_valid;

  funnel_if #(.N_REQ(4), .MODE_W(8)) bus ();

  funnel_arb #(.N_REQ(4), .MODE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input bit [3:0] req, input int last);
    for (int o = 1; o <= 4; o++) begin
      if (req[(last + o) % 4]) return (last + o) % 4;
    end
    return -1;
  endfunction

  function automatic bit model_mode_ok(input logic [7:0] m);
    logic [2:0] low;
    low = m[2:0];
    return $countones(low) == 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.s_req = '0;
    bus.s_mode = '0;
    bus.f_ack = 1'b0;
    bus.f_cfg_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_last = 3;
    m_mode = 8'h00;
    m_cfg_valid = 1'b0;
  endtask

  task automatic wait_activity(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.s_ack != 0 || bus.f_cfg_req || bus.f_req) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.s_req = 4'hF;
    bus.s_mode = 32'h04040404;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.f_req, bus.f_cfg_req, bus.s_ack, bus.s_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b f_req=%b cfg=%b ack=%b err=%b want all 0",
               bus.busy, bus.f_req, bus.f_cfg_req, bus.s_ack, bus.s_err);
    end
    n_checks++;
    if (bus.grant !== 2'd0 || bus.f_mode !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs: got grant=%0d f_mode=%h want 0/00", bus.grant, bus.f_mode);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    bus.s_mode = 32'h00040004;
    bus.s_req = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (bus.f_cfg_req !== 1'b1 || bus.f_req !== 1'b0 || bus.f_mode !== 8'h04 ||
        bus.grant !== 2'd0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_cfg: got cfg=%b f_req=%b mode=%h grant=%0d busy=%b want 1 0 04 0 1",
               bus.f_cfg_req, bus.f_req, bus.f_mode, bus.grant, bus.busy);
    end
    bus.f_cfg_ack = 1'b1;
    @(negedge clk);
    bus.f_cfg_ack = 1'b0;
    n_checks++;
    if (bus.f_req !== 1'b1 || bus.f_cfg_req !== 1'b0 || bus.grant !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_xfer0: got f_req=%b cfg=%b grant=%0d want 1 0 0",
               bus.f_req, bus.f_cfg_req, bus.grant);
    end
    bus.f_ack = 1'b1;
    #1;
    n_checks++;
    if (bus.s_ack !== 4'b0001 || bus.s_err !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_ack0: got ack=%b err=%b want 0001 0000", bus.s_ack, bus.s_err);
    end
    @(negedge clk);
    bus.f_ack = 1'b0;
    bus.s_req = 4'b0100;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.f_req !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_bubble: got busy=%b f_req=%b want 0 0", bus.busy, bus.f_req);
    end
    @(negedge clk);
    n_checks++;
    if (bus.f_req !== 1'b1 || bus.f_cfg_req !== 1'b0 || bus.grant !== 2'd2) begin
      n_fail++;
      $display("FAIL basic_xfer2: got f_req=%b cfg=%b grant=%0d want 1 0 2",
               bus.f_req, bus.f_cfg_req, bus.grant);
    end
    bus.f_ack = 1'b1;
    #1;
    n_checks++;
    if (bus.s_ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_ack2: got ack=%b want 0100", bus.s_ack);
    end
    @(negedge clk);
    bus.f_ack = 1'b0;
    bus.s_req = 4'b0000;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.s_mode = 32'h04040404;
    bus.s_req = 4'b1111;
    @(negedge clk);
    bus.f_cfg_ack = 1'b1;
    @(negedge clk);
    bus.f_cfg_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.f_req !== 1'b1 || bus.grant !== 2'(i % 4)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got f_req=%b grant=%0d want 1 %0d",
                 i, bus.f_req, bus.grant, i % 4);
      end
      bus.f_ack = 1'b1;
      #1;
      n_checks++;
      if (bus.s_ack !== 4'(1 << (i % 4))) begin
        n_fail++;
        $display("FAIL rr_ack%0d: got %b want %b", i, bus.s_ack, 4'(1 << (i % 4)));
      end
      @(negedge clk);
      bus.f_ack = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.f_req !== 1'b0 || bus.s_ack !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_bubble%0d: got busy=%b f_req=%b ack=%b want 0 0 0000",
                 i, bus.busy, bus.f_req, bus.s_ack);
      end
      @(negedge clk);
    end
    bus.s_req = 4'b0000;
  endtask

  task automatic test_reject();
    do_reset();
    bus.s_mode = 32'h04040300;
    bus.s_req = 4'b1110;
    @(negedge clk);
    n_checks++;
    if (bus.s_ack !== 4'b0010 || bus.s_err !== 4'b0010 || bus.f_req !== 1'b0 ||
        bus.f_cfg_req !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rej_pulse: got ack=%b err=%b f_req=%b cfg=%b busy=%b want 0010 0010 0 0 0",
               bus.s_ack, bus.s_err, bus.f_req, bus.f_cfg_req, bus.busy);
    end
    bus.s_req = 4'b1100;
    @(negedge clk);
    n_checks++;
    if (bus.s_ack !== 4'b0000 || bus.s_err !== 4'b0000 || bus.f_cfg_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rej_once: got ack=%b err=%b cfg=%b want 0000 0000 0",
               bus.s_ack, bus.s_err, bus.f_cfg_req);
    end
    @(negedge clk);
    n_checks++;
    if (bus.f_cfg_req !== 1'b1 || bus.grant !== 2'd2) begin
      n_fail++;
      $display("FAIL rej_next: got cfg=%b grant=%0d want 1 2", bus.f_cfg_req, bus.grant);
    end
    bus.s_req = 4'b0000;
  endtask

  task automatic test_cfg_delay();
    do_reset();
    bus.s_mode = 32'h00000001;
    bus.s_req = 4'b0001;
    @(negedge clk);
    bus.f_cfg_ack = 1'b1;
    @(negedge clk);
    bus.f_cfg_ack = 1'b0;
    bus.f_ack = 1'b1;
    @(negedge clk);
    bus.f_ack = 1'b0;
    bus.s_mode = 32'h00000002;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.f_cfg_req !== 1'b1 || bus.f_req !== 1'b0 || bus.f_mode !== 8'h02) begin
        n_fail++;
        $display("FAIL cfgdly_c%0d: got cfg=%b f_req=%b mode=%h want 1 0 02",
                 c, bus.f_cfg_req, bus.f_req, bus.f_mode);
      end
    end
    bus.f_cfg_ack = 1'b1;
    @(negedge clk);
    bus.f_cfg_ack = 1'b0;
    n_checks++;
    if (bus.f_req !== 1'b1 || bus.f_cfg_req !== 1'b0 || bus.f_mode !== 8'h02) begin
      n_fail++;
      $display("FAIL cfgdly_xfer: got f_req=%b cfg=%b mode=%h want 1 0 02",
               bus.f_req, bus.f_cfg_req, bus.f_mode);
    end
    bus.s_req = 4'b0000;
  endtask

  task automatic test_req_drop();
    do_reset();
    bus.s_mode = 32'h00000101;
    bus.s_req = 4'b0001;
    @(negedge clk);
    bus.f_cfg_ack = 1'b1;
    @(negedge clk);
    bus.f_cfg_ack = 1'b0;
    bus.s_req = 4'b0010;
    bus.f_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.f_req !== 1'b0 || bus.s_ack !== 4'b0000 || bus.grant !== 2'd0 ||
          bus.f_mode !== 8'h01 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_c%0d: got f_req=%b ack=%b grant=%0d mode=%h busy=%b want 0 0000 0 01 1",
                 c, bus.f_req, bus.s_ack, bus.grant, bus.f_mode, bus.busy);
      end
      @(negedge clk);
    end
    bus.s_req = 4'b0011;
    #1;
    n_checks++;
    if (bus.f_req !== 1'b1 || bus.s_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL drop_resume: got f_req=%b ack=%b want 1 0001", bus.f_req, bus.s_ack);
    end
    @(negedge clk);
    bus.f_ack = 1'b0;
    bus.s_req = 4'b0000;
  endtask

  task automatic test_reset_xfer();
    bit ok;
    do_reset();
    bus.s_mode = 32'h00040000;
    bus.s_req = 4'b0100;
    @(negedge clk);
    bus.f_cfg_ack = 1'b1;
    @(negedge clk);
    bus.f_cfg_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.f_req, bus.f_cfg_req, bus.s_ack, bus.s_err} !== 11'd0 ||
        bus.grant !== 2'd0 || bus.f_mode !== 8'h00) begin
      n_fail++;
      $display("FAIL rstx_idle: got busy=%b f_req=%b cfg=%b ack=%b grant=%0d mode=%h want all 0",
               bus.busy, bus.f_req, bus.f_cfg_req, bus.s_ack, bus.grant, bus.f_mode);
    end
    wait_activity(ok);
    n_checks++;
    if (!ok || bus.f_cfg_req !== 1'b1 || bus.f_mode !== 8'h04) begin
      n_fail++;
      $display("FAIL rstx_recfg: got seen=%b cfg=%b mode=%h want 1 1 04", ok, bus.f_cfg_req,
               bus.f_mode);
    end
    bus.s_req = 4'b0000;
  endtask

  task automatic test_random();
    bit [3:0]   pend;
    logic [7:0] md    [4];
    logic [7:0] mlist [8];
    int         k;
    int         it;
    int         dl;
    bit         ok;
    mlist = '{8'h01, 8'h02, 8'h04, 8'h03, 8'h00, 8'h07, 8'h81, 8'h0c};
    md = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    pend = 4'b0000;
    it = 0;
    while (it < 60 || pend != 0) begin
      if (it < 60) begin
        for (int j = 0; j < 4; j++) begin
          if (!pend[j] && $urandom_range(0, 1) == 1) begin
            pend[j] = 1'b1;
            md[j] = mlist[$urandom_range(0, 7)];
          end
        end
      end
      it++;
      bus.s_mode = {md[3], md[2], md[1], md[0]};
      bus.s_req = pend;
      if (pend == 0) continue;
      k = model_pick(pend, m_last);
      wait_activity(ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_timeout: no activity for requester %0d", k);
        do_reset();
        pend = 4'b0000;
        continue;
      end
      if (!model_mode_ok(md[k])) begin
        n_checks++;
        if (bus.s_ack !== 4'(1 << k) || bus.s_err !== 4'(1 << k) || bus.f_req !== 1'b0 ||
            bus.f_cfg_req !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_reject: got ack=%b err=%b f_req=%b cfg=%b want req %0d rejected",
                   bus.s_ack, bus.s_err, bus.f_req, bus.f_cfg_req, k);
        end
        pend[k] = 1'b0;
        m_last = k;
        continue;
      end
      if (!m_cfg_valid || md[k] != m_mode) begin
        dl = $urandom_range(0, 3);
        for (int d = 0; d <= dl; d++) begin
          if (d > 0) @(negedge clk);
          n_checks++;
          if (bus.f_cfg_req !== 1'b1 || bus.f_req !== 1'b0 || bus.f_mode !== md[k] ||
              bus.grant !== 2'(k) || bus.s_ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL rand_cfg: got cfg=%b f_req=%b mode=%h grant=%0d ack=%b want 1 0 %h %0d 0",
                     bus.f_cfg_req, bus.f_req, bus.f_mode, bus.grant, bus.s_ack, md[k], k);
          end
        end
        bus.f_cfg_ack = 1'b1;
        @(negedge clk);
        bus.f_cfg_ack = 1'b0;
        m_mode = md[k];
        m_cfg_valid = 1'b1;
      end
      dl = $urandom_range(0, 3);
      for (int d = 0; d <= dl; d++) begin
        if (d > 0) @(negedge clk);
        n_checks++;
        if (bus.f_req !== 1'b1 || bus.f_cfg_req !== 1'b0 || bus.grant !== 2'(k) ||
            bus.f_mode !== m_mode || bus.s_ack !== 4'b0000) begin
          n_fail++;
          $display("FAIL rand_xfer: got f_req=%b cfg=%b grant=%0d mode=%h ack=%b want 1 0 %0d %h 0",
                   bus.f_req, bus.f_cfg_req, bus.grant, bus.f_mode, bus.s_ack, k, m_mode);
        end
      end
      bus.f_ack = 1'b1;
      #1;
      n_checks++;
      if (bus.s_ack !== 4'(1 << k) || bus.s_err !== 4'b0000) begin
        n_fail++;
        $display("FAIL rand_ack: got ack=%b err=%b want %b 0000", bus.s_ack, bus.s_err,
                 4'(1 << k));
      end
      @(negedge clk);
      bus.f_ack = 1'b0;
      pend[k] = 1'b0;
      m_last = k;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.f_req !== 1'b0 || bus.s_ack !== 4'b0000) begin
        n_fail++;
        $display("FAIL rand_bubble: got busy=%b f_req=%b ack=%b want 0 0 0000",
                 bus.busy, bus.f_req, bus.s_ack);
      end
    end
    bus.s_req = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.s_req = '0;
    bus.s_mode = '0;
    bus.f_ack = 1'b0;
    bus.f_cfg_ack = 1'b0;
    m_last = 3;
    m_mode = 8'h00;
    m_cfg_valid = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_reject();
    test_cfg_delay();
    test_req_drop();
    test_reset_xfer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/funnel_arb.md
FUNNEL_ARB -- requirements
Module: funnel_arb

Interface
REQ-001 Parameters: N_REQ, default 4, number of upstream requesters; MODE_W, default 8, funnel mode width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s_req  input  N_REQ  per-requester frame request; held until matching s_ack.
REQ-005 s_ack  output  N_REQ  per-requester frame completion or reject; one-cycle pulse.
REQ-006 s_mode  input  N_REQ*MODE_W  per-requester funnel mode; slice k is bits [k*MODE_W+MODE_W-1 : k*MODE_W].
REQ-007 s_err  output  N_REQ  one-cycle pulse, coincident with s_ack, marking a rejected frame.
REQ-008 f_req  output  1  frame request to funnel controller target port.
REQ-009 f_ack  input  1  funnel frame-complete acknowledge.
REQ-010 f_cfg_req  output  1  funnel configuration request.
REQ-011 f_cfg_ack  input  1  funnel configuration acknowledge.
REQ-012 f_mode  output  MODE_W  registered mode driven to the funnel.
REQ-013 grant  output  clog2(N_REQ)  index of the currently owning requester.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, CFG, XFER.
REQ-016 In IDLE with any s_req high, the arbiter SHALL pick round-robin, searching from last_grant+1 upward with wrap, and latch the index into grant.
REQ-017 A mode SHALL be valid only when its bits [2:0] are exactly one-hot (001, 010, 100).
REQ-018 Invalid mode from the picked requester: IDLE SHALL pulse s_ack[k] and s_err[k] in the next cycle, update last_grant=k, stay IDLE, and issue no funnel traffic.
REQ-019 Valid mode equal to f_mode with cfg_valid=1: IDLE->XFER.
REQ-020 Valid mode otherwise: IDLE->CFG, registering f_mode on the transition.
REQ-021 CFG SHALL hold f_cfg_req=1 until f_cfg_ack, then set cfg_valid=1 and go to XFER; f_cfg_ack received in the entry cycle is accepted.
REQ-022 In XFER, f_req SHALL equal s_req[grant] combinationally, and s_ack[grant] SHALL equal f_ack & f_req.
REQ-023 XFER->IDLE on f_req & f_ack; last_grant SHALL be set to grant on that cycle.
REQ-024 If s_req[grant] drops in XFER, the arbiter SHALL remain in XFER holding grant and f_mode, so the funnel's mid-frame state is preserved.
REQ-025 f_mode SHALL be constant whenever the FSM is outside IDLE->CFG transitions.
REQ-026 Other requesters' s_ack and s_err SHALL remain 0 while any grant is held.
REQ-027 Latency from s_req rise (FSM in IDLE) to f_req: 1 cycle on mode match; 2 cycles minimum on a mode change.
REQ-028 Every completed frame SHALL be followed by exactly one IDLE bubble cycle.
REQ-029 f_req and f_cfg_req SHALL never be high in the same cycle.

Reset
REQ-030 On reset: state=IDLE, last_grant=N_REQ-1 (requester 0 first), grant=0, f_mode=0, cfg_valid=0, all req/ack/err outputs 0, busy=0.
REQ-031 Reset asserted mid-CFG or mid-XFER SHALL abort without any s_ack; integration SHALL reset the funnel in the same cycle.

Structure
REQ-032 Package funnel_pkg SHALL hold N_REQ, MODE_W, REDUCT_W=3, and the state enum.
REQ-033 The round-robin search SHALL be a combinational sub-module, funnel_rr_pick (inputs: req vector and last index; outputs: hit flag and index).

Verification
REQ-034 After reset, s_req=4'b0101, both modes 8'h04 -> CFG with f_mode=04, then grant 0 XFER; after its f_ack, grant 2 XFER with no CFG.
REQ-035 All four requesters continuously requesting with the same valid mode -> grants 0,1,2,3,0 in order, one bubble cycle between frames.
REQ-036 Requester 1 mode 8'h03 -> s_ack[1]=s_err[1]=1 for one cycle, f_req and f_cfg_req stay 0, and next pick starts at 2.
REQ-037 Mode change 8'h01->8'h02 with f_cfg_ack delayed 5 cycles -> f_cfg_req high 5 cycles, f_req low throughout, f_mode=02 stable.
REQ-038 s_req[grant] deasserted 3 cycles mid-XFER -> grant and f_mode unchanged, no s_ack, frame completes on re-assertion plus f_ack.
REQ-039 reset pulsed in XFER -> next cycle IDLE, all outputs 0, cfg_valid=0, so the next frame passes through CFG.
